// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: issues mult/multu/div/divu from the EX stage to the shared
// pipelined multiplier and iterative divider. It stalls the pipeline while
// the operation runs and holds the HI/LO result until the instruction
// leaves EX. A flush kills any work in flight.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic        op_valid,
    input  logic        op_mult,
    input  logic        op_multu,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stallreq,
    output logic        res_valid,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sign_q, sign_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    // Decode. Multiplies win over divides, and signed wins over unsigned
    // within each pair. So the signed flag is that of the highest-priority op.
    logic any_op, is_mul, sign_sel, issue;
    assign any_op   = op_mult | op_multu | op_div | op_divu;
    assign is_mul   = op_mult | op_multu;
    assign sign_sel = op_mult | (~op_multu & op_div);
    assign issue    = op_valid & any_op & ~flush;

    // The multiplier sees live operands in the issue cycle. After that it
    // sees the latched copies, so its pipeline input stays stable.
    assign mul_ina    = (state_q == IDLE) ? src_a   : a_q;
    assign mul_inb    = (state_q == IDLE) ? src_b   : b_q;
    assign mul_signed = (state_q == IDLE) ? op_mult : sign_q;

    assign div_op1    = a_q;
    assign div_op2    = b_q;
    assign div_signed = sign_q;

    assign hi_o = hi_q;
    assign lo_o = lo_q;

    // Next-state and output decode. Flush is applied last so that it
    // overrides every state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stallreq  = 1'b0;
        res_valid = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;

        case (state_q)
            IDLE: begin
                stallreq = issue;
                if (issue) begin
                    a_d    = src_a;
                    b_d    = src_b;
                    sign_d = sign_sel;
                    if (is_mul) begin
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                        state_d = MUL_WAIT;
                    end else if (src_b != 32'd0) begin
                        state_d = DIV_WAIT;
                    end else begin
                        // A divide by zero never reaches the divider.
                        // The result is fixed: remainder = dividend, quotient = all ones.
                        hi_d    = src_a;
                        lo_d    = 32'hFFFF_FFFF;
                        state_d = DONE;
                    end
                end
            end
            MUL_WAIT: begin
                stallreq = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    {hi_d, lo_d} = mul_result;
                    state_d      = DONE;
                end
            end
            DIV_WAIT: begin
                stallreq  = 1'b1;
                div_start = ~div_ready;
                if (div_ready) begin
                    {hi_d, lo_d} = div_result;
                    state_d      = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (!ex_hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            if (state_q == DIV_WAIT) begin
                div_annul = 1'b1;
                div_start = 1'b0;
            end
        end
    end

    // State, counter, latched operands and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl. It uses a behavioural 2-stage multiplier and a
// 33-cycle divider, runs a vector table of ops, and then runs hand-written
// sequences for flush, hold and mid-operation reset.
`timescale 1ns/1ps
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0, ex_hold = 1'b0, op_valid = 1'b0;
    logic        op_mult = 1'b0, op_multu = 1'b0, op_div = 1'b0, op_divu = 1'b0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        stallreq, res_valid, mul_signed, div_start, div_signed, div_annul;
    logic [31:0] hi_o, lo_o, mul_ina, mul_inb, div_op1, div_op2;
    logic [63:0] mul_result, div_result;
    logic        div_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(2), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .ex_hold(ex_hold),
        .op_valid(op_valid), .op_mult(op_mult), .op_multu(op_multu),
        .op_div(op_div), .op_divu(op_divu), .src_a(src_a), .src_b(src_b),
        .stallreq(stallreq), .res_valid(res_valid), .hi_o(hi_o), .lo_o(lo_o),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
        .div_op1(div_op1), .div_op2(div_op2), .div_annul(div_annul),
        .div_result(div_result), .div_ready(div_ready)
    );

    // Multiplier model with two pipeline stages (latency 2).
    logic [63:0] mp1, mp2;
    always @(posedge clk) begin
        mp1 <= {{32{mul_signed & mul_ina[31]}}, mul_ina} *
               {{32{mul_signed & mul_inb[31]}}, mul_inb};
        mp2 <= mp1;
    end
    assign mul_result = mp2;

    // Divider model. Ready rises after 33 cycles of div_start and lasts one cycle.
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
        logic [31:0] q, r;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    int          dcnt;
    logic        mready;
    logic [63:0] mres;
    logic        extra_ready = 1'b0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dcnt <= 0; mready <= 1'b0; mres <= '0;
        end else if (div_annul) begin
            dcnt <= 0; mready <= 1'b0;
        end else if (mready) begin
            dcnt <= 0; mready <= 1'b0;
        end else if (div_start) begin
            if (dcnt == 32) begin
                mready <= 1'b1;
                mres   <= div_model(div_op1, div_op2, div_signed);
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end
    assign div_ready  = mready | extra_ready;
    assign div_result = extra_ready ? 64'hDEAD_BEEF_CAFE_F00D : mres;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [3:0] flags);
        {op_divu, op_div, op_multu, op_mult} = flags;
    endtask

    // Issue one op, run it to completion, check the result, then retire it.
    task automatic run_op(input string name, input logic [3:0] flags,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int es, input int eds);
        int stalls = 0;
        int starts = 0;
        int guard  = 0;
        int overlap = 0;
        @(posedge clk); #1;
        set_ops(flags); op_valid = 1'b1; src_a = a; src_b = b;
        #1;
        while (!res_valid && guard < 200) begin
            if (stallreq) stalls++;
            if (div_start) starts++;
            if (div_start && div_ready) overlap++;
            @(posedge clk); #2;
            guard++;
        end
        check({name, " res_valid"}, res_valid, 1);
        check({name, " stall_cycles"}, stalls, es);
        check({name, " div_start_cycles"}, starts, eds);
        check({name, " start_ready_overlap"}, overlap, 0);
        check({name, " hi"}, hi_o, eh);
        check({name, " lo"}, lo_o, el);
        check({name, " done_stall"}, stallreq, 0);
        $display("op %s a=%h b=%h -> hi=%h lo=%h stalls=%0d", name, a, b, hi_o, lo_o, stalls);
        @(posedge clk); #1;
        op_valid = 1'b0; set_ops(4'b0000);
        #1;
        check({name, " leave_res_valid"}, res_valid, 0);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  flags;   // {divu, div, multu, mult}
        logic [31:0] a, b, hi, lo;
        int          stalls;
        int          starts;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{"mult_m1x2",   4'b0001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 0};
        tbl[1]  = '{"multu_m1x2",  4'b0010, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 3, 0};
        tbl[2]  = '{"div_m7d2",    4'b0100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 35, 33};
        tbl[3]  = '{"divu_100d7",  4'b1000, 32'd100,      32'd7, 32'd2,        32'd14,       35, 33};
        tbl[4]  = '{"divu_5d0",    4'b1000, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, 1, 0};
        tbl[5]  = '{"mult_7xm3",   4'b0001, 32'd7,  32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 3, 0};
        tbl[6]  = '{"div_5d0",     4'b0100, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, 1, 0};
        tbl[7]  = '{"multu_big",   4'b0010, 32'h10000, 32'h10000, 32'h00000001, 32'h00000000, 3, 0};
        tbl[8]  = '{"prio_mult",   4'b0011, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 0};
        tbl[9]  = '{"prio_div",    4'b1100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 35, 33};
        tbl[10] = '{"prio_multu",  4'b0110, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 3, 0};

        // Reset state, checked while reset is still asserted.
        #1;
        check("rst stallreq", stallreq, 0);
        check("rst res_valid", res_valid, 0);
        check("rst hi", hi_o, 0);
        check("rst lo", lo_o, 0);
        check("rst div_start", div_start, 0);
        check("rst div_annul", div_annul, 0);
        #21 resetn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].name, tbl[i].flags, tbl[i].a, tbl[i].b,
                   tbl[i].hi, tbl[i].lo, tbl[i].stalls, tbl[i].starts);
        end

        // Flush 10 cycles into a divide. The result must be dropped and annul must pulse once.
        @(posedge clk); #1;
        set_ops(4'b0100); op_valid = 1'b1; src_a = 32'd50; src_b = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1; op_valid = 1'b0; set_ops(4'b0000);
        #1;
        check("flush annul", div_annul, 1);
        check("flush div_start", div_start, 0);
        @(posedge clk); #1 flush = 1'b0;
        #1;
        check("flush annul_once", div_annul, 0);
        check("flush start_low", div_start, 0);
        check("flush res_valid", res_valid, 0);
        check("flush stallreq", stallreq, 0);
        check("flush hi_kept", hi_o, tbl[10].hi);
        check("flush lo_kept", lo_o, tbl[10].lo);
        $display("flush during div: annul pulsed, hi=%h lo=%h", hi_o, lo_o);
        @(posedge clk); #1 extra_ready = 1'b1;
        #1 check("late_ready div_start", div_start, 0);
        @(posedge clk); #1 extra_ready = 1'b0;
        #1;
        check("late_ready res_valid", res_valid, 0);
        check("late_ready hi", hi_o, tbl[10].hi);
        check("late_ready lo", lo_o, tbl[10].lo);
        $display("late div_ready ignored: hi=%h lo=%h", hi_o, lo_o);

        // Hold in DONE with the op still asserted. It must not be re-issued.
        begin
            int guard = 0;
            @(posedge clk); #1;
            set_ops(4'b0001); op_valid = 1'b1; src_a = 32'd3; src_b = 32'd5;
            #1;
            while (!res_valid && guard < 50) begin
                @(posedge clk); #2;
                guard++;
            end
            check("hold first res_valid", res_valid, 1);
            check("hold lo", lo_o, 32'd15);
            ex_hold = 1'b1; src_a = 32'd9;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #2;
                check("hold res_valid", res_valid, 1);
                check("hold stallreq", stallreq, 0);
                check("hold mul_ina", mul_ina, 32'd3);
                $display("hold cycle %0d: res_valid=%b stallreq=%b mul_ina=%h", k, res_valid, stallreq, mul_ina);
            end
            ex_hold = 1'b0;
            @(posedge clk); #1 op_valid = 1'b0; set_ops(4'b0000);
            #1;
            check("hold release res_valid", res_valid, 0);
            check("hold release idle mul_ina", mul_ina, 32'd9);
        end

        // Asynchronous reset in the middle of MUL_WAIT.
        @(posedge clk); #1;
        set_ops(4'b0001); op_valid = 1'b1; src_a = 32'd6; src_b = 32'd7;
        @(posedge clk); #2;
        check("pre_reset stallreq", stallreq, 1);
        resetn = 1'b0; op_valid = 1'b0; set_ops(4'b0000);
        #1;
        check("async_rst stallreq", stallreq, 0);
        check("async_rst res_valid", res_valid, 0);
        check("async_rst hi", hi_o, 0);
        check("async_rst lo", lo_o, 0);
        check("async_rst div_start", div_start, 0);
        check("async_rst div_annul", div_annul, 0);
        $display("async reset mid-mult: hi=%h lo=%h", hi_o, lo_o);
        @(negedge clk) resetn = 1'b1;
        run_op("rst_mult_and_div", 4'b0101, 32'd6, 32'd7, 32'd0, 32'd42, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
